// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Radix-2 shift-add multiply, restoring divide, one step per cycle.
module mdu_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   mdu_op,
    input  logic [DATA_WIDTH-1:0] mdu_src0,
    input  logic [DATA_WIDTH-1:0] mdu_src1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] mdu_res
);

    localparam int W = DATA_WIDTH;

    localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_DIVU   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(6);

    localparam logic [W-1:0]         MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] LAST    = CNT_WIDTH'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                state;
    logic [OP_WIDTH-1:0]   op_q;
    logic                  neg_q;
    logic [W-1:0]          hi_q;
    logic [W-1:0]          lo_q;
    logic [W-1:0]          opnd_q;
    logic [CNT_WIDTH-1:0]  cnt;

    logic         sgn0;
    logic         sgn1;
    logic         neg_in;
    logic         div_in;
    logic         div0;
    logic         ovf;
    logic         mzero;
    logic         fast;
    logic [W-1:0] mag0;
    logic [W-1:0] mag1;
    logic [W-1:0] fast_res;

    always_comb begin
        div_in = mdu_op[2];
        sgn0   = 1'b0;
        sgn1   = 1'b0;
        unique case (mdu_op)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn0 = mdu_src0[W-1];
                sgn1 = mdu_src1[W-1];
            end
            OP_MULHSU: sgn0 = mdu_src0[W-1];
            default: ;
        endcase
        mag0 = sgn0 ? -mdu_src0 : mdu_src0;
        mag1 = sgn1 ? -mdu_src1 : mdu_src1;
        // remainder follows the dividend, everything else the xor of signs
        neg_in = (div_in && mdu_op[1]) ? sgn0 : (sgn0 ^ sgn1);
        div0   = div_in && (mdu_src1 == '0);
        ovf    = (mdu_op == OP_DIV || mdu_op == OP_REM)
              && (mdu_src0 == MIN_NEG) && (mdu_src1 == '1);
        mzero  = !div_in && (mdu_src0 == '0 || mdu_src1 == '0);
        fast   = div0 || ovf || mzero;
        fast_res = '0;
        unique case (1'b1)
            div0:    fast_res = mdu_op[1] ? mdu_src0 : '1;
            ovf:     fast_res = mdu_op[1] ? '0 : MIN_NEG;
            default: fast_res = '0;
        endcase
    end

    logic [W:0]   add_sum;
    logic [W:0]   div_sh;
    logic [W:0]   div_diff;
    logic [W-1:0] nxt_hi;
    logic [W-1:0] nxt_lo;

    always_comb begin
        add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {hi_q, lo_q[W-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        nxt_hi   = hi_q;
        nxt_lo   = lo_q;
        if (op_q[2]) begin
            if (div_diff[W]) begin
                nxt_hi = div_sh[W-1:0];
                nxt_lo = {lo_q[W-2:0], 1'b0};
            end else begin
                nxt_hi = div_diff[W-1:0];
                nxt_lo = {lo_q[W-2:0], 1'b1};
            end
        end else begin
            nxt_hi = add_sum[W:1];
            nxt_lo = {add_sum[0], lo_q[W-1:1]};
        end
    end

    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s;
    logic [W-1:0]   rem_s;
    logic [W-1:0]   fin_res;

    always_comb begin
        prod   = {nxt_hi, nxt_lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -nxt_lo : nxt_lo;
        rem_s  = neg_q ? -nxt_hi : nxt_hi;
        unique case (op_q)
            OP_MUL:                       fin_res = prod_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_s[2*W-1:W];
            OP_DIV, OP_DIVU:              fin_res = quo_s;
            default:                      fin_res = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mdu_res   <= '0;
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= mdu_op;
                        neg_q    <= neg_in;
                        cnt      <= '0;
                        hi_q     <= '0;
                        lo_q     <= div_in ? mag0 : mag1;
                        opnd_q   <= div_in ? mag1 : mag0;
                        in_ready <= 1'b0;
                        if (fast) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            mdu_res   <= fast_res;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi_q <= nxt_hi;
                    lo_q <= nxt_lo;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        mdu_res   <= fin_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit; the sequential companion to the combinational execute-stage ALU.
- Implements the RV32M operation set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) over a configurable data width.
- Uses a valid/ready handshake on both sides, so the pipeline can stall the EX stage while an operation runs.
- Accepts a pipeline flush that aborts an in-flight operation.

Parameters:
- DATA_WIDTH, 32, operand/result width; even, >= 4.
- OP_WIDTH, 3, op field width; encoding equals RV32M funct3.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns unit to IDLE.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- mdu_op  input  OP_WIDTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- mdu_src0  input  DATA_WIDTH  rs1 (multiplicand / dividend).
- mdu_src1  input  DATA_WIDTH  rs2 (multiplier / divisor).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- mdu_res  output  DATA_WIDTH  result.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, mdu_res=0, counter=0, internal operand registers=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: an edge with state=IDLE, in_valid=1, flush=0. Op and operands are latched at this edge; inputs are don't-care afterwards.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: src0 signed, src1 unsigned.
  - DIV/REM: both operands signed.
  - All other ops: unsigned.
- Signed operands are converted to magnitude at accept; the result sign is applied when entering DONE.
- Multiply: radix-2 shift-add over a 2*DATA_WIDTH product.
  - MUL returns the low DATA_WIDTH bits.
  - MULH/MULHSU/MULHU return the high DATA_WIDTH bits of the correctly signed product.
- Divide: restoring division, one quotient bit per cycle.
  - Quotient rounds toward zero.
  - Remainder takes the sign of the dividend.
- Normal timing:
  - IDLE->CALC at the accept edge; counter=0.
  - One iteration per CALC edge.
  - CALC->DONE at the edge completing iteration DATA_WIDTH.
  - out_valid is therefore first high after edge DATA_WIDTH+1 counted from the accept edge (33 for W=32).
- Fast path (IDLE->DONE at the accept edge, out_valid high after 1 edge):
  - Divisor==0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (DIV/REM with src0=MIN_NEG, src1=-1): DIV returns MIN_NEG; REM returns 0.
  - Either multiply operand ==0: result 0.
- DONE: mdu_res is held stable while out_valid=1 && out_ready=0 (back-pressure of any length).
  - An edge with out_valid=1 && out_ready=1 moves DONE->IDLE.
  - No new request can be accepted in the same cycle; accepts resume the next cycle.
- mdu_res keeps its last value in IDLE/CALC. Consumers sample it only while out_valid=1.
- flush=1 at an edge: from any state go to IDLE; out_valid=0 after the edge; counter cleared.
  - A simultaneous in_valid is not accepted (flush has priority).
  - A simultaneous out_ready handshake in DONE is discarded; the consumer must also flush.
- rstn asserted mid-operation: immediate return to reset values, independent of clk.
- in_valid while busy: ignored (in_ready=0); the requester must hold the request.
- No X propagation: all registers have reset values; the default op path cannot occur because every encoding is defined.

Test Plan:
- Reset/idle:
  - Drive rstn=0 mid-CALC -> out_valid=0 and in_ready=1 immediately.
  - Release rstn -> mdu_res=0, state IDLE.
- Multiply:
  - MUL 0x0000_0007 x 0xFFFF_FFFD -> 0xFFFF_FFEB, out_valid after exactly 33 edges.
  - MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000.
  - MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE.
  - MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF.
- Divide:
  - DIV -7/2 -> 0xFFFF_FFFD.
  - REM -7/2 -> 0xFFFF_FFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - Each with 33-edge latency.
- Special cases (1-edge latency):
  - DIV x/0 -> 0xFFFF_FFFF.
  - REMU 0x1234/0 -> 0x1234.
  - DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000.
  - REM 0x8000_0000/0xFFFF_FFFF -> 0.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles in DONE -> mdu_res stable, in_ready=0.
  - Raise out_ready -> IDLE next edge; back-to-back request accepted the following cycle.
- Flush:
  - Assert flush at iteration 15 of a DIV -> IDLE next edge, no out_valid pulse.
  - Assert flush together with in_valid in IDLE -> request not accepted.
  - Next request after the flush produces a correct result.
